// File: rtl/mar_ram_responder_pkg.sv
// Shared constants and types for the MAR-addressed program/data RAM.
// The MAR and bus blocks import the same widths so the pointer interface stays consistent.
package mar_ram_responder_pkg;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } ld_state_e;

  localparam logic [DW-1:0] MEM_CLEAR = '0;
endpackage

// File: rtl/mar_ram_responder_ram_loader_fsm.sv
// Boot-load controller. It walks ld_ptr from 0 to DEPTH-1 over a valid/ready byte stream
// and hands the top a write port for the load path.
module ram_loader_fsm #(
  parameter int AW    = mar_ram_responder_pkg::AW,
  parameter int DW    = mar_ram_responder_pkg::DW,
  parameter int DEPTH = mar_ram_responder_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_mode,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic [AW-1:0] ld_ptr,
  output logic          run_en,
  output logic          load_we,
  output logic [AW-1:0] load_addr,
  output logic [DW-1:0] load_data
);
  import mar_ram_responder_pkg::*;

  ld_state_e     state, next_state;
  logic [AW-1:0] ptr, next_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // An abort (ld_mode low) outranks reaching FULL; a byte offered on that edge is still written.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      RUN: begin
        if (ld_mode) begin
          next_state = LOAD;
          next_ptr   = '0;
        end
      end
      LOAD: begin
        if (!ld_mode) begin
          next_state = RUN;
          next_ptr   = '0;
        end else if (ld_valid) begin
          if (ptr == AW'(DEPTH - 1)) begin
            next_state = FULL;
            next_ptr   = '0;
          end else begin
            next_ptr = ptr + AW'(1);
          end
        end
      end
      FULL: begin
        if (!ld_mode) next_state = RUN;
      end
      default: begin
        next_state = RUN;
        next_ptr   = '0;
      end
    endcase
  end

  always_comb begin
    ld_ready  = (state == LOAD);
    ld_done   = (state == FULL);
    run_en    = (state == RUN);
    load_we   = (state == LOAD) && ld_valid;
    load_addr = ptr;
    load_data = ld_data;
    ld_ptr    = ptr;
  end
endmodule

// File: rtl/mar_ram_responder.sv
// 16x8 RAM answering the MAR pointer. It does registered run-mode reads and synchronous
// writes, and it is filled by a boot-load stream before the CPU runs.
module mar_ram_responder #(
  parameter int AW    = mar_ram_responder_pkg::AW,
  parameter int DW    = mar_ram_responder_pkg::DW,
  parameter int DEPTH = mar_ram_responder_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_in,
  input  logic          ram_rd,
  input  logic          ram_wr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          ld_mode,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic [AW-1:0] ld_ptr
);
  import mar_ram_responder_pkg::*;

  logic [DW-1:0] mem [DEPTH];
  logic          run_en;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [DW-1:0] rd_data_p1;
  logic          vld_p1;

  ram_loader_fsm #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_mode   (ld_mode),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .ld_ptr    (ld_ptr),
    .run_en    (run_en),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  // Load and run writes never coincide: load_we needs LOAD, the run write needs RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= MEM_CLEAR;
    end else if (load_we) begin
      mem[load_addr] <= load_data;
    end else if (run_en && ram_wr) begin
      mem[addr_in] <= wr_data;
    end
  end

  // p1: registered read; sampling mem before the write lands gives read-before-write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= MEM_CLEAR;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= run_en && ram_rd;
      if (run_en && ram_rd) rd_data_p1 <= mem[addr_in];
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;
endmodule

// File: tb/tb_mar_ram_responder.sv
// Bench for mar_ram_responder: directed scenarios plus a randomized phase, all checked
// each cycle against a behavioural model of the RAM and its load mode.
module tb_mar_ram_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] addr_in = '0;
  logic       ram_rd = 1'b0;
  logic       ram_wr = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ld_mode = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready;
  logic       ld_done;
  logic [3:0] ld_ptr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mar_ram_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr_in  (addr_in),
    .ram_rd   (ram_rd),
    .ram_wr   (ram_wr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ld_mode  (ld_mode),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_ptr   (ld_ptr)
  );

  // Behavioural model: mode 0 = run, 1 = loading, 2 = loaded; m_ptr counts accepted bytes.
  logic [7:0] m_mem [16];
  int         m_mode = 0;
  int         m_ptr = 0;
  logic [7:0] m_rd = '0;
  logic       m_vld = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_mode = 0;
      m_ptr  = 0;
      m_rd   = 8'h00;
      m_vld  = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (m_mode == 0) begin
        if (ram_rd) begin
          m_rd  = m_mem[addr_in];
          m_vld = 1'b1;
        end
        if (ram_wr) m_mem[addr_in] = wr_data;
        if (ld_mode) begin
          m_mode = 1;
          m_ptr  = 0;
        end
      end else if (m_mode == 1) begin
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          m_ptr = m_ptr + 1;
        end
        if (!ld_mode) begin
          m_mode = 0;
          m_ptr  = 0;
        end else if (m_ptr == 16) begin
          m_mode = 2;
          m_ptr  = 0;
        end
      end else if (!ld_mode) begin
        m_mode = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_rd_valid", 8'(rd_valid), 8'(m_vld));
    chk("cyc_rd_data", rd_data, m_rd);
    chk("cyc_ld_ready", 8'(ld_ready), 8'(m_mode == 1));
    chk("cyc_ld_done", 8'(ld_done), 8'(m_mode == 2));
    chk("cyc_ld_ptr", 8'(ld_ptr), 8'(m_ptr));
  end

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    addr_in = a;
    ram_rd  = 1'b1;
    @(posedge clk);
    #1;
    chk(name, rd_data, exp);
    chk({name, "_vld"}, 8'(rd_valid), 8'h01);
    @(negedge clk);
    ram_rd = 1'b0;
  endtask

  task automatic stream(input int n, input logic [7:0] base);
    @(negedge clk);
    ld_mode = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      chk("stream_ready", 8'(ld_ready), 8'h01);
      ld_valid = 1'b1;
      ld_data  = base + 8'(i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int cyc;

    // 1: reset then read
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", 8'(rd_valid), 8'h00);
    chk("rst_ld_ptr", 8'(ld_ptr), 8'h00);
    chk("rst_ld_ready", 8'(ld_ready), 8'h00);
    chk("rst_ld_done", 8'(ld_done), 8'h00);
    do_read(4'h7, 8'h00, "t1_read7");
    @(posedge clk);
    #1;
    chk("t1_vld_one_cycle", 8'(rd_valid), 8'h00);

    // 2: full boot load
    stream(16, 8'h10);
    chk("t2_done", 8'(ld_done), 8'h01);
    chk("t2_ready_low", 8'(ld_ready), 8'h00);
    chk("t2_model_pin", m_mem[9], 8'h19);
    ld_mode = 1'b0;
    @(negedge clk);
    chk("t2_done_drop", 8'(ld_done), 8'h00);
    do_read(4'h0, 8'h10, "t2_read0");
    do_read(4'h9, 8'h19, "t2_read9");
    do_read(4'hF, 8'h1F, "t2_read15");

    // 3: load with gaps, then abort after 5 accepts
    @(negedge clk);
    ld_mode = 1'b1;
    @(negedge clk);
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 100) begin
      ld_valid = (cyc % 2) == 0;
      if (ld_valid) begin
        ld_data = 8'hC0 + 8'(k);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    ld_valid = 1'b0;
    chk("t3_accepts", 8'(k), 8'h05);
    chk("t3_ptr5", 8'(ld_ptr), 8'h05);
    ld_mode = 1'b0;
    @(negedge clk);
    chk("t3_abort_ptr", 8'(ld_ptr), 8'h00);
    chk("t3_abort_ready", 8'(ld_ready), 8'h00);
    for (int a = 0; a < 5; a++) do_read(4'(a), 8'hC0 + 8'(a), "t3_loaded");
    do_read(4'h5, 8'h15, "t3_kept5");
    @(negedge clk);
    ld_mode = 1'b1;
    @(negedge clk);
    chk("t3_reentry_ptr", 8'(ld_ptr), 8'h00);
    chk("t3_reentry_ready", 8'(ld_ready), 8'h01);
    ld_mode = 1'b0;
    @(negedge clk);

    // 4: run-mode write, then read-before-write on the same address
    addr_in = 4'h3;
    ram_wr  = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_data = 8'h5A;
    ram_rd  = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_rbw_old", rd_data, 8'hA5);
    @(negedge clk);
    ram_wr = 1'b0;
    ram_rd = 1'b0;
    do_read(4'h3, 8'h5A, "t4_read_new");

    // 5: strobes ignored in LOAD and in FULL
    @(negedge clk);
    ld_mode = 1'b1;
    @(negedge clk);
    addr_in = 4'h2;
    wr_data = 8'hFF;
    ram_wr  = 1'b1;
    ram_rd  = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_load_no_vld", 8'(rd_valid), 8'h00);
    @(negedge clk);
    ram_wr  = 1'b0;
    ram_rd  = 1'b0;
    ld_mode = 1'b0;
    @(negedge clk);
    do_read(4'h2, 8'hC2, "t5_load_kept2");
    stream(16, 8'h20);
    chk("t5_full", 8'(ld_done), 8'h01);
    addr_in = 4'h2;
    wr_data = 8'hFF;
    ram_wr  = 1'b1;
    ram_rd  = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_full_no_vld", 8'(rd_valid), 8'h00);
    @(negedge clk);
    ram_wr  = 1'b0;
    ram_rd  = 1'b0;
    ld_mode = 1'b0;
    @(negedge clk);
    do_read(4'h2, 8'h22, "t5_full_kept2");

    // 6: asynchronous reset mid-load
    stream(8, 8'h30);
    chk("t6_ptr8", 8'(ld_ptr), 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ptr", 8'(ld_ptr), 8'h00);
    chk("t6_async_ready", 8'(ld_ready), 8'h00);
    chk("t6_async_rd_data", rd_data, 8'h00);
    chk("t6_async_rd_valid", 8'(rd_valid), 8'h00);
    chk("t6_async_done", 8'(ld_done), 8'h00);
    ld_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_read(4'h0, 8'h00, "t6_read0");
    do_read(4'h7, 8'h00, "t6_read7");

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) ld_mode = ~ld_mode;
      ld_valid = 1'($urandom);
      ld_data  = 8'($urandom);
      ram_rd   = 1'($urandom);
      ram_wr   = 1'($urandom);
      addr_in  = 4'($urandom);
      wr_data  = 8'($urandom);
    end
    @(negedge clk);
    ld_mode  = 1'b0;
    ld_valid = 1'b0;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 16; a++) do_read(4'(a), m_mem[a], "sweep_read");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
